avalon_multi_timer: RTL and testbench



---
 rtl/avalon_multi_timer.sv | 204 ++++++++++++++++++++
 tb/tb_avalon_multi_timer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_multi_timer.sv
// avalon_multi_timer: NUM_CH independent down-counting interval timers behind one 32-bit
// Avalon-MM slave. Define MULTI_TIMER_PWM_EN to enable the per-channel COMPARE/PWM outputs.
module avalon_multi_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int ADDR_W       = 6,
  parameter int RESET_PERIOD = 49999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] timeout_pulse,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int CH_W = ADDR_W - 3;

  localparam logic [2:0] OFF_CONTROL = 3'd0;
  localparam logic [2:0] OFF_STATUS  = 3'd1;
  localparam logic [2:0] OFF_PERIOD  = 3'd2;
  localparam logic [2:0] OFF_SNAP    = 3'd3;
  localparam logic [2:0] OFF_COMPARE = 3'd4;

  localparam logic [CNT_W-1:0]  RESET_CNT     = CNT_W'(RESET_PERIOD);
  localparam logic [ADDR_W-1:0] IRQ_PEND_ADDR = ADDR_W'(NUM_CH * 8);

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  snap_q   [NUM_CH];
  logic [NUM_CH-1:0] run_q;
  logic [NUM_CH-1:0] to_q;
  logic [NUM_CH-1:0] ito_q;
  logic [NUM_CH-1:0] cont_q;
  logic [NUM_CH-1:0] pol_q;

`ifdef MULTI_TIMER_PWM_EN
  logic [CNT_W-1:0]  cmp_q [NUM_CH];
  logic [NUM_CH-1:0] pwm_q;
  logic [NUM_CH-1:0] wr_cmp;
`endif

  logic              wr_en;
  logic [CH_W-1:0]   addr_ch;
  logic [2:0]        addr_off;
  logic [CNT_W-1:0]  wr_val;
  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] wr_stat;
  logic [NUM_CH-1:0] wr_period;
  logic [NUM_CH-1:0] wr_snap;
  logic [NUM_CH-1:0] evt;
  logic [NUM_CH-1:0] pend;
  logic [31:0]       rd_next;
  logic              unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign addr_ch      = address[ADDR_W-1:3];
  assign addr_off     = address[2:0];
  assign wr_val       = writedata[CNT_W-1:0];
  assign unused_wdata = ^writedata;

  // Per-channel write strobes, timeout events and pending interrupts.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ctrl   = '0;
    wr_stat   = '0;
    wr_period = '0;
    wr_snap   = '0;
    evt       = '0;
    pend      = '0;
`ifdef MULTI_TIMER_PWM_EN
    wr_cmp    = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_en && addr_ch == CH_W'(i)) begin
        wr_ctrl[i]   = (addr_off == OFF_CONTROL);
        wr_stat[i]   = (addr_off == OFF_STATUS);
        wr_period[i] = (addr_off == OFF_PERIOD);
        wr_snap[i]   = (addr_off == OFF_SNAP);
`ifdef MULTI_TIMER_PWM_EN
        wr_cmp[i]    = (addr_off == OFF_COMPARE);
`endif
      end
      evt[i]  = run_q[i] && (cnt_q[i] == '0);
      pend[i] = to_q[i] && ito_q[i];
    end
  end

  assign timeout_pulse = evt;
  assign irq           = |pend;

  // Host writes take priority over the running count; STOP beats START.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the per-channel arrays are architectural registers with defined reset
      // values, not RAM, so they are reset along with the rest of the state.
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= RESET_CNT;
        period_q[i] <= RESET_CNT;
        snap_q[i]   <= '0;
      end
      run_q  <= '0;
      to_q   <= '0;
      ito_q  <= '0;
      cont_q <= '0;
      pol_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // NOTE: sequential state uses non-blocking assignments so every channel
        // sees the pre-edge values regardless of statement order.
        if (wr_period[i]) begin
          period_q[i] <= wr_val;
          cnt_q[i]    <= wr_val;
        end else if (run_q[i]) begin
          cnt_q[i] <= evt[i] ? period_q[i] : cnt_q[i] - CNT_W'(1);
        end

        if (wr_period[i]) begin
          run_q[i] <= 1'b0;
        end else if (wr_ctrl[i] && writedata[3]) begin
          run_q[i] <= 1'b0;
        end else if (wr_ctrl[i] && writedata[2]) begin
          run_q[i] <= 1'b1;
        end else if (evt[i] && !cont_q[i]) begin
          run_q[i] <= 1'b0;
        end

        if (wr_ctrl[i]) begin
          ito_q[i]  <= writedata[0];
          cont_q[i] <= writedata[1];
          pol_q[i]  <= writedata[4];
        end

        // A timeout in the same cycle as a clear keeps the flag set.
        if (evt[i]) begin
          to_q[i] <= 1'b1;
        end else if (wr_stat[i]) begin
          to_q[i] <= 1'b0;
        end

        if (wr_snap[i]) begin
          snap_q[i] <= cnt_q[i];
        end
      end
    end
  end

`ifdef MULTI_TIMER_PWM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cmp_q[i] <= '0;
      end
      pwm_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_cmp[i]) begin
          cmp_q[i] <= wr_val;
        end
        pwm_q[i] <= (run_q[i] && (cnt_q[i] < cmp_q[i])) ^ pol_q[i];
      end
    end
  end

  assign pwm_out = pwm_q;
`else
  assign pwm_out = '0;
`endif

  // Read mux: reserved offsets and unmapped addresses return 0.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_ch == CH_W'(i)) begin
        case (addr_off)
          OFF_CONTROL: rd_next = 32'({pol_q[i], 2'b00, cont_q[i], ito_q[i]});
          OFF_STATUS:  rd_next = 32'({run_q[i], to_q[i]});
          OFF_PERIOD:  rd_next = 32'(period_q[i]);
          OFF_SNAP:    rd_next = 32'(snap_q[i]);
`ifdef MULTI_TIMER_PWM_EN
          OFF_COMPARE: rd_next = 32'(cmp_q[i]);
`endif
          default:     rd_next = '0;
        endcase
      end
    end
    if (address == IRQ_PEND_ADDR) begin
      rd_next = 32'(pend);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Self-checking bench for avalon_multi_timer: a cycle-level reference model compared every
// cycle, plus directed register accesses with hand-computed expectations.
module tb_avalon_multi_timer;

  localparam int NUM_CH       = 4;
  localparam int CNT_W        = 32;
  localparam int ADDR_W       = 6;
  localparam int RESET_PERIOD = 49999;
`ifdef MULTI_TIMER_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] timeout_pulse;
  logic [NUM_CH-1:0] pwm_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  avalon_multi_timer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .RESET_PERIOD(RESET_PERIOD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .timeout_pulse(timeout_pulse), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_period [NUM_CH];
  logic [31:0] m_cnt    [NUM_CH];
  logic [31:0] m_snap   [NUM_CH];
  logic [31:0] m_cmp    [NUM_CH];
  bit          m_run    [NUM_CH];
  bit          m_to     [NUM_CH];
  bit          m_ito    [NUM_CH];
  bit          m_cont   [NUM_CH];
  bit          m_pol    [NUM_CH];
  bit [NUM_CH-1:0] m_pwm;
  logic [31:0] m_rd;

  function automatic logic [31:0] model_read(input int a);
    logic [31:0] p;
    int ch;
    int off;
    p   = '0;
    ch  = a / 8;
    off = a % 8;
    if (a == NUM_CH * 8) begin
      for (int i = 0; i < NUM_CH; i++) p[i] = m_to[i] & m_ito[i];
      return p;
    end
    if (ch >= NUM_CH) return 32'd0;
    case (off)
      0:       return {27'd0, m_pol[ch], 2'b00, m_cont[ch], m_ito[ch]};
      1:       return {30'd0, m_run[ch], m_to[ch]};
      2:       return m_period[ch];
      3:       return m_snap[ch];
      4:       return PWM ? m_cmp[ch] : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    logic [31:0] old_cnt;
    logic [31:0] d;
    bit          ev;
    bit          wr;
    int          ch;
    int          off;
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_period[i] = RESET_PERIOD;
        m_cnt[i]    = RESET_PERIOD;
        m_snap[i]   = 0;
        m_cmp[i]    = 0;
        m_run[i]    = 0;
        m_to[i]     = 0;
        m_ito[i]    = 0;
        m_cont[i]   = 0;
        m_pol[i]    = 0;
      end
      m_pwm = '0;
      m_rd  = '0;
    end else begin
      m_rd = model_read(int'(address));
      wr   = chipselect && !write_n;
      ch   = int'(address) / 8;
      off  = int'(address) % 8;
      d    = writedata;
      for (int i = 0; i < NUM_CH; i++) begin
        old_cnt  = m_cnt[i];
        ev       = m_run[i] && (m_cnt[i] == 0);
        m_pwm[i] = PWM && ((m_run[i] && (m_cnt[i] < m_cmp[i])) != m_pol[i]);
        if (m_run[i]) begin
          if (ev) begin
            m_to[i]  = 1;
            m_cnt[i] = m_period[i];
            if (!m_cont[i]) m_run[i] = 0;
          end else begin
            m_cnt[i] = m_cnt[i] - 1;
          end
        end
        if (wr && ch == i) begin
          case (off)
            0: begin
              m_ito[i]  = d[0];
              m_cont[i] = d[1];
              m_pol[i]  = d[4];
              if (d[3]) m_run[i] = 0;
              else if (d[2]) m_run[i] = 1;
            end
            1: if (!ev) m_to[i] = 0;
            2: begin m_period[i] = d; m_cnt[i] = d; m_run[i] = 0; end
            3: m_snap[i] = old_cnt;
            4: if (PWM) m_cmp[i] = d;
            default: ;
          endcase
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin : compare
    logic [NUM_CH-1:0] pulse_exp;
    logic              irq_exp;
    if (checking && reset_n) begin
      irq_exp = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        pulse_exp[i] = m_run[i] && (m_cnt[i] == 0);
        irq_exp      = irq_exp | (m_to[i] & m_ito[i]);
      end
      check("readdata", readdata, m_rd);
      check("irq", 32'(irq), 32'(irq_exp));
      check("timeout_pulse", 32'(timeout_pulse), 32'(pulse_exp));
      check("pwm_out", 32'(pwm_out), 32'(m_pwm));
    end
  end

  // Pulse tally and cycle counter for the directed checks.
  int cyc = 0;
  int pulse_cnt [NUM_CH];
  int last_evt  [NUM_CH];
  initial for (int i = 0; i < NUM_CH; i++) begin pulse_cnt[i] = 0; last_evt[i] = -1; end
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (timeout_pulse[i]) begin
          pulse_cnt[i]++;
          last_evt[i] = cyc;
        end
      end
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wr(input int a, input logic [31:0] d);
    address    = ADDR_W'(a);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    address = ADDR_W'(a);
    @(posedge clk); #1;
    d = readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_pwm(input int ch, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      hi += int'(pwm_out[ch]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    logic [31:0] d;
    int p;
    int c0;
    int hi;

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n  = 1'b1;
    checking = 1'b1;
    check("reset irq", 32'(irq), 32'd0);
    check("reset pwm_out", 32'(pwm_out), 32'd0);
    check("reset timeout_pulse", 32'(timeout_pulse), 32'd0);
    rd(2, d);  check("ch0 PERIOD after reset", d, 32'd49999);
    rd(1, d);  check("ch0 STATUS after reset", d, 32'd0);
    rd(0, d);  check("ch0 CONTROL after reset", d, 32'd0);

    // ch1 continuous, period 9 -> one event every 10 cycles
    wr(10, 9);
    p = pulse_cnt[1];
    wr(8, 32'h7);
    idle(30);
    check("ch1 pulses in 30 cycles", 32'(pulse_cnt[1] - p), 32'd3);
    rd(32, d); check("IRQ_PEND ch1", d, 32'h2);
    wr(8, 32'hB);
    wr(9, 0);
    rd(9, d);  check("ch1 STATUS after stop+clear", d, 32'd0);
    check("irq after clear", 32'(irq), 32'd0);
    rd(13, d); check("ch1 reserved offset", d, 32'd0);
    rd(40, d); check("unmapped address", d, 32'd0);

    // ch0 one-shot, period 3
    wr(2, 3);
    p = pulse_cnt[0];
    wr(0, 32'h4);
    c0 = cyc;
    idle(10);
    check("ch0 one-shot pulse count", 32'(pulse_cnt[0] - p), 32'd1);
    check("ch0 one-shot pulse cycle", 32'(last_evt[0] - c0), 32'd3);
    rd(1, d);  check("ch0 STATUS after one-shot", d, 32'h1);
    wr(3, 0);
    rd(3, d);  check("ch0 counter holds PERIOD", d, 32'd3);
    rd(0, d);  check("ch0 CONTROL start not stored", d, 32'd0);

    // ch2: clear coinciding with a timeout, then START+STOP
    wr(18, 4);
    wr(16, 32'h6);
    idle(4);
    wr(17, 0);
    rd(17, d); check("ch2 set wins over clear", d, 32'h3);
    wr(16, 32'hC);
    p = pulse_cnt[2];
    idle(20);
    check("ch2 no pulses after stop", 32'(pulse_cnt[2] - p), 32'd0);
    rd(17, d); check("ch2 STATUS after START+STOP", d, 32'h1);

    // ch3: snapshot while running, PERIOD write mid-count
    wr(26, 100);
    wr(24, 32'h6);
    idle(7);
    wr(27, 0);
    rd(27, d); check("ch3 SNAP running", d, 32'd93);
    wr(26, 50);
    rd(25, d); check("ch3 STATUS after PERIOD write", d, 32'd0);
    wr(27, 0);
    rd(27, d); check("ch3 counter reloaded", d, 32'd50);

    // PWM on ch3
    wr(28, 3);
    wr(26, 9);
    wr(24, 32'h6);
    idle(2);
    count_pwm(3, 20, hi);
    check("ch3 pwm high count pol0", 32'(hi), PWM ? 32'd6 : 32'd0);
    wr(24, 32'h12);
    idle(2);
    count_pwm(3, 20, hi);
    check("ch3 pwm high count pol1", 32'(hi), PWM ? 32'd14 : 32'd0);
    rd(28, d); check("ch3 COMPARE readback", d, PWM ? 32'd3 : 32'd0);
    rd(24, d); check("ch3 CONTROL readback", d, 32'h12);
    wr(24, 32'h18);
    idle(3);
    check("ch3 pwm idle level", 32'(pwm_out[3]), PWM ? 32'd1 : 32'd0);

    // reset asserted mid-count
    wr(10, 9);
    wr(8, 32'h7);
    idle(5);
    reset_n = 1'b0;
    #1;
    check("mid-count reset pulse", 32'(timeout_pulse), 32'd0);
    check("mid-count reset irq", 32'(irq), 32'd0);
    check("mid-count reset pwm", 32'(pwm_out), 32'd0);
    idle(2);
    reset_n = 1'b1;
    rd(10, d); check("ch1 PERIOD after reset", d, 32'd49999);
    rd(9, d);  check("ch1 STATUS after reset", d, 32'd0);
    idle(3);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
